ms_section_collector: RTL and testbench
=======================================

// Module: ms_section_collector
// PURPOSE
//  Parametrised multi-channel slave collector for master-slave shared-variable inputs.
//  Each of NUM_CH channels carries a signed value plus a one-cycle sync strobe.
//  A two-section FSM gathers one sample from every enabled channel, reduces them (sum or max),
//  and offers the result on a valid/ready output. Sits between master producers and a consumer.
// PARAMETERS
//  WIDTH    32  signed width of each channel value
//  NUM_CH   4   number of channels (>=1)
//  DROP_W   8   width of saturating dropped-sample counter
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  async reset, active-high
//  s_in       in   NUM_CH*WIDTH       channel values, ch i at [i*WIDTH +: WIDTH], signed
//  s_in_sync  in   NUM_CH             per-channel sync strobe; value valid when high
//  ch_en      in   NUM_CH             channel enable mask; disabled channels not awaited
//  mode       in   1                  0 = signed sum, 1 = signed max
//  out_data   out  WIDTH+$clog2(NUM_CH)+1  reduced result, signed
//  out_valid  out  1                  result available
//  out_ready  in   1                  consumer accepts result
//  section_o  out  1                  current section (0 COLLECT, 1 EMIT)
//  drop_cnt   out  DROP_W             samples dropped while in EMIT, saturating
// BEHAVIOUR
//  Reset: section=COLLECT, val regs=0, got mask=0, out_data=0, out_valid=0, drop_cnt=0.
//  COLLECT: per channel i, s_in_sync[i]&ch_en[i] -> val[i]<=s_in[i], got[i]<=1.
//   Repeat sync on an already-got channel overwrites val[i]; latest wins, no drop.
//   Sync on disabled channel ignored, not counted.
//  Completion: evaluated on registered got: (got & ch_en)==ch_en and ch_en!=0.
//   On completion: out_data<=reduce(val over ch_en), out_valid<=1, section<=EMIT.
//   Latency: last sync at cycle t -> out_valid high at t+2.
//  ch_en==0: never completes; FSM stays in COLLECT.
//  ch_en changing mid-COLLECT: next completion check uses the new mask; got bits retained.
//  Reduce: sum sign-extends each val to out width, no overflow possible. Max is a signed
//   compare of enabled vals only, sign-extended. mode is sampled on the completion cycle.
//  EMIT: out_data held stable while out_valid=1 and !out_ready.
//   out_ready&out_valid -> out_valid<=0, got<=0, section<=COLLECT.
//   Any enabled sync during EMIT, including the handshake cycle: sample discarded,
//   drop_cnt += popcount(s_in_sync & ch_en), saturating at all-ones.
//  out_ready while !out_valid: no effect.
//  Async reset mid-operation: immediate return to reset values; pending result lost.
// STRUCTURE
//  Package ms_section_collector_pkg: enum ms_sections_e {SEC_COLLECT, SEC_EMIT},
//   mode constants MODE_SUM=1'b0, MODE_MAX=1'b1, function out_width(WIDTH,NUM_CH).
//  Sub-module ms_reduce: combinational sum/max tree over NUM_CH signed values with mask
//   and mode. The FSM, registers and counter stay in the top module.
// TESTING
//  Reset then NUM_CH=4, ch_en=4'hF, mode=0, syncs vals 1,2,3,-4 on one cycle
//   -> out_valid at t+2, out_data=2.
//  mode=1, vals -5,-1,-7,-3 staggered over 4 cycles -> out_data=-1 two cycles after last sync.
//  ch_en=4'b0101, sync only ch0=10, ch2=20 -> out_data=30. ch1/ch3 syncs ignored, drop_cnt=0.
//  Hold out_ready=0 for 5 cycles in EMIT with 2 enabled syncs per cycle
//   -> out_data stable, drop_cnt=10. Then ready=1 -> COLLECT next cycle, got cleared.
//  DROP_W=2, 6 drops in EMIT -> drop_cnt=3 (saturated).
//  ch_en=0 for 20 cycles with syncs -> out_valid stays 0.
//  Assert rst mid-EMIT -> out_valid=0 and section_o=0 immediately, before the next edge.

Source files
------------

// File: rtl/ms_section_collector_pkg.sv
// Shared types and helpers for the master-slave section collector.
package ms_section_collector_pkg;

  typedef enum logic {
    SEC_COLLECT = 1'b0,
    SEC_EMIT    = 1'b1
  } ms_sections_e;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Result width: room for the sum of NUM_CH signed values without overflow.
  function automatic int out_width(input int width, input int num_ch);
    return width + $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/ms_reduce.sv
// Combinational masked reduction (signed sum or signed max) over NUM_CH channel values.
module ms_reduce
  import ms_section_collector_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  localparam int OW    = out_width(WIDTH, NUM_CH)
) (
  input  logic [NUM_CH*WIDTH-1:0] vals,
  input  logic [NUM_CH-1:0]       mask,
  input  logic                    mode,
  output logic [OW-1:0]           result
);

  logic signed [OW-1:0]    sum_acc;
  logic signed [OW-1:0]    max_acc;
  logic signed [OW-1:0]    ext;
  logic signed [WIDTH-1:0] elem;
  logic                    seen;

  // Walk the enabled channels; max starts from the first enabled value, not from a constant.
  always_comb begin
    sum_acc = '0;
    max_acc = '0;
    ext     = '0;
    elem    = '0;
    seen    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      elem = vals[i*WIDTH +: WIDTH];
      ext  = OW'(elem);
      if (mask[i]) begin
        sum_acc = sum_acc + ext;
        if (!seen || (ext > max_acc)) begin
          max_acc = ext;
        end
        seen = 1'b1;
      end
    end
    result = (mode == MODE_MAX) ? max_acc : sum_acc;
  end

endmodule

// File: rtl/ms_section_collector.sv
// Multi-channel slave collector: gathers one sample per enabled channel (COLLECT),
// then offers the reduced result on a valid/ready port (EMIT), counting samples
// that arrive while the result is pending.
module ms_section_collector
  import ms_section_collector_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int DROP_W = 8,
  localparam int OW    = out_width(WIDTH, NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] s_in,
  input  logic [NUM_CH-1:0]       s_in_sync,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    mode,
  output logic [OW-1:0]           out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    section_o,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int PW = $clog2(NUM_CH + 1);
  localparam int SW = DROP_W + PW;

  ms_sections_e            state;
  ms_sections_e            state_nxt;
  logic [NUM_CH*WIDTH-1:0] val;
  logic [NUM_CH-1:0]       got;
  logic                    complete;
  logic                    handshake;
  logic [OW-1:0]           red;
  logic [PW-1:0]           drop_pop;
  logic [SW-1:0]           drop_sum;
  logic [DROP_W-1:0]       drop_nxt;

  ms_reduce #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH)
  ) u_reduce (
    .vals   (val),
    .mask   (ch_en),
    .mode   (mode),
    .result (red)
  );

  // Section register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEC_COLLECT;
    else     state <= state_nxt;
  end

  // Next section: completion looks at the registered got mask against the live enable mask.
  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    handshake = 1'b0;
    case (state)
      SEC_COLLECT: begin
        if (((got & ch_en) == ch_en) && (ch_en != '0)) begin
          complete  = 1'b1;
          state_nxt = SEC_EMIT;
        end
      end
      SEC_EMIT: begin
        if (out_valid && out_ready) begin
          handshake = 1'b1;
          state_nxt = SEC_COLLECT;
        end
      end
      default: state_nxt = SEC_COLLECT;
    endcase
  end

  // Sample capture, result register and output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val       <= '0;
      got       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == SEC_COLLECT) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (s_in_sync[i] && ch_en[i]) begin
            val[i*WIDTH +: WIDTH] <= s_in[i*WIDTH +: WIDTH];
            got[i]                <= 1'b1;
          end
        end
      end
      if (complete) begin
        out_data  <= red;
        out_valid <= 1'b1;
      end
      if (handshake) begin
        out_valid <= 1'b0;
        got       <= '0;
      end
    end
  end

  // Saturating increment by the number of enabled strobes seen this cycle.
  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_pop = drop_pop + PW'(s_in_sync[i] & ch_en[i]);
    end
    drop_sum = SW'(drop_cnt) + SW'(drop_pop);
    drop_nxt = (drop_sum[SW-1:DROP_W] != '0) ? '1 : drop_sum[DROP_W-1:0];
  end

  // Dropped-sample counter: only strobes that arrive while a result is pending count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    drop_cnt <= '0;
    else if (state == SEC_EMIT) drop_cnt <= drop_nxt;
  end

  assign section_o = state;

endmodule

// File: tb/tb_ms_section_collector.sv
// Self-checking bench for ms_section_collector with an expected-result scoreboard.
module tb_ms_section_collector;
  import ms_section_collector_pkg::*;

  localparam int WIDTH  = 32;
  localparam int NUM_CH = 4;
  localparam int OW     = out_width(WIDTH, NUM_CH);

  logic                    clk;
  logic                    rst;
  logic [NUM_CH*WIDTH-1:0] s_in;
  logic [NUM_CH-1:0]       s_in_sync;
  logic [NUM_CH-1:0]       ch_en;
  logic                    mode;
  logic                    out_ready;
  logic [OW-1:0]           out_data;
  logic                    out_valid;
  logic                    section_o;
  logic [7:0]              drop_cnt;
  logic [OW-1:0]           s_out_data;
  logic                    s_out_valid;
  logic                    s_section_o;
  logic [1:0]              s_drop_cnt;

  int errors = 0;
  int checks = 0;
  logic [OW-1:0] sb[$];

  ms_section_collector #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync), .ch_en(ch_en),
    .mode(mode), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .section_o(section_o), .drop_cnt(drop_cnt)
  );

  // Narrow drop counter variant, same stimulus, to exercise saturation.
  ms_section_collector #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DROP_W(2)) dut_sat (
    .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync), .ch_en(ch_en),
    .mode(mode), .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .section_o(s_section_o), .drop_cnt(s_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] m, input int v0, input int v1, input int v2, input int v3);
    s_in      = {32'(v3), 32'(v2), 32'(v1), 32'(v0)};
    s_in_sync = m;
    @(posedge clk);
    @(negedge clk);
    s_in_sync = '0;
  endtask

  // Called at the negedge following the last sync: result must appear one cycle later (t+2).
  task automatic expect_result(input string tag);
    int cyc;
    logic [OW-1:0] exp;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd1);
    if (out_valid) begin
      chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        chk({tag, "_data"}, 64'(out_data), 64'(exp));
      end
      chk({tag, "_section"}, 64'(section_o), 64'd1);
    end
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_acc_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_acc_section"}, 64'(section_o), 64'd0);
  endtask

  initial begin
    logic seen_valid;
    rst = 1'b1; s_in = '0; s_in_sync = '0; ch_en = '0; mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid",   64'(out_valid), 64'd0);
    chk("rst_section", 64'(section_o), 64'd0);
    chk("rst_data",    64'(out_data),  64'd0);
    chk("rst_drop",    64'(drop_cnt),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Sum, all channels on one cycle.
    ch_en = 4'hF; mode = MODE_SUM;
    sb.push_back(OW'(2));
    pulse(4'hF, 1, 2, 3, -4);
    chk("sum1_early_valid", 64'(out_valid), 64'd0);
    expect_result("sum1");
    chk("sum1_sat_data", 64'(s_out_data), 64'(OW'(2)));
    accept("sum1");

    // Max, staggered syncs.
    mode = MODE_MAX;
    sb.push_back(OW'(-1));
    pulse(4'b0001, -5, -1, -7, -3);
    pulse(4'b0010, -5, -1, -7, -3);
    pulse(4'b0100, -5, -1, -7, -3);
    chk("max_partial_valid", 64'(out_valid), 64'd0);
    pulse(4'b1000, -5, -1, -7, -3);
    expect_result("max");
    accept("max");

    // Partial enable mask; disabled-channel syncs ignored.
    mode = MODE_SUM; ch_en = 4'b0101;
    sb.push_back(OW'(30));
    pulse(4'hF, 10, 99, 20, 77);
    expect_result("mask");
    chk("mask_drop", 64'(drop_cnt), 64'd0);

    // Back-pressure: two enabled syncs per cycle while pending.
    for (int k = 1; k <= 5; k++) begin
      s_in      = {32'(1000), 32'(1000), 32'(1000), 32'(1000)};
      s_in_sync = 4'hF;
      @(posedge clk);
      @(negedge clk);
      chk("hold_data",  64'(out_data),  64'(OW'(30)));
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_drop",  64'(drop_cnt),  64'(2 * k));
      chk("hold_sat",   64'(s_drop_cnt), 64'((2 * k > 3) ? 3 : 2 * k));
    end
    // Handshake cycle still counts enabled syncs as drops.
    s_in_sync = 4'hF;
    accept("hold");
    s_in_sync = '0;
    chk("hs_drop",     64'(drop_cnt),   64'd12);
    chk("hs_sat_drop", 64'(s_drop_cnt), 64'd3);

    // got must have been cleared: one channel alone may not complete.
    pulse(4'b0001, 5, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("gotclr_valid", 64'(out_valid), 64'd0);
    sb.push_back(OW'(11));
    pulse(4'b0100, 0, 0, 6, 0);
    expect_result("gotclr");
    accept("gotclr");

    // No channels enabled: never completes.
    ch_en = '0;
    seen_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      s_in_sync = 4'hF;
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    s_in_sync = '0;
    chk("en0_valid", 64'(seen_valid), 64'd0);
    chk("en0_drop",  64'(drop_cnt),   64'd12);

    // Async reset while a result is pending.
    ch_en = 4'hF; mode = MODE_SUM;
    sb.push_back(OW'(34));
    pulse(4'hF, 7, 8, 9, 10);
    expect_result("rstmid");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid",   64'(out_valid),  64'd0);
    chk("rstmid_section", 64'(section_o),  64'd0);
    chk("rstmid_data",    64'(out_data),   64'd0);
    chk("rstmid_drop",    64'(drop_cnt),   64'd0);
    chk("rstmid_sat",     64'(s_drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
